// File: rtl/hpu_pkg.sv
//------------------------------------------------------------------------------
// hpu_pkg
//   Shared types and constants for the dcache line-refill sequencer.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package hpu_pkg;

    typedef enum logic [2:0] {
        DCL_IDLE   = 3'd0,
        DCL_EV_RLO = 3'd1,
        DCL_EV_RHI = 3'd2,
        DCL_EV_CAP = 3'd3,
        DCL_EV_WVC = 3'd4,
        DCL_WR_LO  = 3'd5,
        DCL_WR_HI  = 3'd6,
        DCL_DONE   = 3'd7
    } dcl_refill_st_e;

    localparam logic [1:0] HALF_NONE = 2'b00;
    localparam logic [1:0] HALF_LO   = 2'b10;
    localparam logic [1:0] HALF_HI   = 2'b11;

endpackage

`default_nettype wire

// File: rtl/dcache_vc_way_sel.sv
//------------------------------------------------------------------------------
// dcache_vc_way_sel
//   Victim-cache way picker: lowest invalid way, else round-robin pointer.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dcache_vc_way_sel #(
    parameter  int VC_WAYS_EXP = 2,
    localparam int VC_WAYS     = 2**VC_WAYS_EXP
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [VC_WAYS-1:0]     vc_valid_i,
    input  logic                   take_i,
    output logic [VC_WAYS_EXP-1:0] way_o
);

    logic [VC_WAYS_EXP-1:0] rr_ptr_q;
    logic [VC_WAYS_EXP-1:0] rr_ptr_d;
    logic                   w_free_found;

    // The pointer only advances when every way is occupied and one is consumed.
    always_comb begin
        way_o        = rr_ptr_q;
        w_free_found = 1'b0;
        for (int i = 0; i < VC_WAYS; i++) begin
            if (!w_free_found && !vc_valid_i[i]) begin
                way_o        = VC_WAYS_EXP'(i);
                w_free_found = 1'b1;
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (take_i && !w_free_found) begin
            rr_ptr_d = rr_ptr_q + VC_WAYS_EXP'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dcache_line_refill.sv
//------------------------------------------------------------------------------
// dcache_line_refill
//   Refill sequencer: optional victim eviction to the VC, then two-beat L1 fill.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dcache_line_refill
    import hpu_pkg::*;
#(
    parameter  int AWT           = 32,
    parameter  int WORD_SEL      = 4,
    parameter  int L1_WAYS       = 2,
    parameter  int VC_WAYS_EXP   = 2,
    parameter  int LINE_DWT      = 512,
    parameter  int HALF_LINE_DWT = 256,
    parameter  int LSU_DC_SWT    = 4,
    localparam int TAG_WT_VC     = AWT - WORD_SEL - 2,
    localparam int VC_WAYS       = 2**VC_WAYS_EXP
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic [AWT-1:0]                    req_addr_i,
    input  logic [L1_WAYS-1:0]                req_way_i,
    input  logic [LINE_DWT-1:0]               req_data_i,
    input  logic                              victim_valid_i,
    input  logic [TAG_WT_VC-1:0]              victim_tag_i,
    input  logic [VC_WAYS-1:0]                vc_valid_i,
    output logic [L1_WAYS-1:0]                rd_l1d_en_o,
    output logic [1:0]                        rd_l1d_half_en_o,
    output logic [AWT-1:0]                    rd_l1d_addr_o,
    input  logic [HALF_LINE_DWT*L1_WAYS-1:0]  rd_l1d_half_i,
    input  logic [L1_WAYS-1:0]                rw_conflict_i,
    output logic [L1_WAYS-1:0]                wr_l1d_en_o,
    output logic [1:0]                        wr_l1d_half_en_o,
    output logic [AWT-1:0]                    wr_l1d_addr_o,
    output logic [HALF_LINE_DWT-1:0]          wr_l1d_data_o,
    output logic [LSU_DC_SWT-1:0]             wr_l1d_strb_o,
    output logic [L1_WAYS-1:0]                wr_l1d_tag_en_o,
    output logic                              wr_vc_en_o,
    output logic                              wr_vc_line_en_o,
    output logic [VC_WAYS_EXP-1:0]            wr_vc_way_o,
    output logic [LINE_DWT-1:0]               wr_vc_data_o,
    output logic                              wr_vc_tag_en_o,
    output logic [TAG_WT_VC-1:0]              wr_vc_tag_o,
    output logic                              busy_o,
    output logic                              done_o
);

    dcl_refill_st_e                 state_q, state_d;
    logic [AWT-1:0]                 addr_q, addr_d;
    logic [L1_WAYS-1:0]             way_q, way_d;
    logic [LINE_DWT-1:0]            line_q, line_d;
    logic [TAG_WT_VC-1:0]           vtag_q, vtag_d;
    logic [HALF_LINE_DWT-1:0]       lo_q, lo_d;
    logic                           rhi_first_q, rhi_first_d;

    logic [L1_WAYS-1:0]             rd_en_q, rd_en_d;
    logic [1:0]                     rd_half_q, rd_half_d;
    logic [L1_WAYS-1:0]             wr_en_q, wr_en_d;
    logic [1:0]                     wr_half_q, wr_half_d;
    logic [HALF_LINE_DWT-1:0]       wr_data_q, wr_data_d;
    logic [LSU_DC_SWT-1:0]          wr_strb_q, wr_strb_d;
    logic [L1_WAYS-1:0]             wr_tag_en_q, wr_tag_en_d;
    logic                           vc_en_q, vc_en_d;
    logic [VC_WAYS_EXP-1:0]         vc_way_q, vc_way_d;
    logic [LINE_DWT-1:0]            vc_data_q, vc_data_d;
    logic [TAG_WT_VC-1:0]           vc_tag_q, vc_tag_d;
    logic                           busy_q, busy_d;
    logic                           ready_q, ready_d;
    logic                           done_q, done_d;

    logic                           w_accept;
    logic                           w_conflict;
    logic [HALF_LINE_DWT-1:0]       w_rd_sel;
    logic [VC_WAYS_EXP-1:0]         w_vc_way;
    logic                           w_vc_take;
    logic                           w_unused_addr;

    assign w_unused_addr = ^req_addr_i[WORD_SEL+1:0];
    assign w_accept      = req_valid_i && ready_q;
    assign w_conflict    = |(rw_conflict_i & way_q);
    assign w_vc_take     = (state_q == DCL_EV_CAP);

    always_comb begin
        w_rd_sel = '0;
        for (int i = 0; i < L1_WAYS; i++) begin
            if (way_q[i]) begin
                w_rd_sel = w_rd_sel | rd_l1d_half_i[i*HALF_LINE_DWT +: HALF_LINE_DWT];
            end
        end
    end

    dcache_vc_way_sel #(
        .VC_WAYS_EXP (VC_WAYS_EXP)
    ) u_vc_way_sel (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .vc_valid_i (vc_valid_i),
        .take_i     (w_vc_take),
        .way_o      (w_vc_way)
    );

    // Next state and datapath; outputs below are decoded from the *next*
    // state so that every RAM strobe is a flop output aligned with its state.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        way_d       = way_q;
        line_d      = line_q;
        vtag_d      = vtag_q;
        lo_d        = lo_q;
        vc_way_d    = vc_way_q;
        vc_data_d   = vc_data_q;
        vc_tag_d    = vc_tag_q;
        wr_data_d   = wr_data_q;

        unique case (state_q)
            DCL_IDLE: begin
                if (w_accept) begin
                    addr_d                 = req_addr_i;
                    addr_d[WORD_SEL+1:0]   = '0;
                    way_d                  = req_way_i;
                    line_d                 = req_data_i;
                    vtag_d                 = victim_tag_i;
                    state_d                = victim_valid_i ? DCL_EV_RLO : DCL_WR_LO;
                end
            end
            DCL_EV_RLO: begin
                if (!w_conflict) state_d = DCL_EV_RHI;
            end
            DCL_EV_RHI: begin
                // Read data of the low-half issue only appears on the first cycle here.
                if (rhi_first_q) lo_d = w_rd_sel;
                if (!w_conflict) state_d = DCL_EV_CAP;
            end
            DCL_EV_CAP: begin
                vc_data_d = {w_rd_sel, lo_q};
                vc_tag_d  = vtag_q;
                vc_way_d  = w_vc_way;
                state_d   = DCL_EV_WVC;
            end
            DCL_EV_WVC: state_d = DCL_WR_LO;
            DCL_WR_LO:  state_d = DCL_WR_HI;
            DCL_WR_HI:  state_d = DCL_DONE;
            DCL_DONE:   state_d = DCL_IDLE;
            default:    state_d = DCL_IDLE;
        endcase

        rhi_first_d = (state_d == DCL_EV_RHI) && (state_q != DCL_EV_RHI);

        rd_en_d     = '0;
        rd_half_d   = HALF_NONE;
        wr_en_d     = '0;
        wr_half_d   = HALF_NONE;
        wr_strb_d   = '0;
        wr_tag_en_d = '0;
        vc_en_d     = 1'b0;
        done_d      = 1'b0;
        busy_d      = (state_d != DCL_IDLE);
        ready_d     = (state_d == DCL_IDLE);

        unique case (state_d)
            DCL_EV_RLO: begin
                rd_en_d   = way_d;
                rd_half_d = HALF_LO;
            end
            DCL_EV_RHI: begin
                rd_en_d   = way_d;
                rd_half_d = HALF_HI;
            end
            DCL_EV_WVC: vc_en_d = 1'b1;
            DCL_WR_LO: begin
                wr_en_d   = way_d;
                wr_half_d = HALF_LO;
                wr_data_d = line_d[HALF_LINE_DWT-1:0];
                wr_strb_d = '1;
            end
            DCL_WR_HI: begin
                wr_en_d     = way_d;
                wr_half_d   = HALF_HI;
                wr_data_d   = line_d[LINE_DWT-1:HALF_LINE_DWT];
                wr_strb_d   = '1;
                wr_tag_en_d = way_d;
            end
            DCL_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= DCL_IDLE;
            addr_q      <= '0;
            way_q       <= '0;
            line_q      <= '0;
            vtag_q      <= '0;
            lo_q        <= '0;
            rhi_first_q <= 1'b0;
            rd_en_q     <= '0;
            rd_half_q   <= HALF_NONE;
            wr_en_q     <= '0;
            wr_half_q   <= HALF_NONE;
            wr_data_q   <= '0;
            wr_strb_q   <= '0;
            wr_tag_en_q <= '0;
            vc_en_q     <= 1'b0;
            vc_way_q    <= '0;
            vc_data_q   <= '0;
            vc_tag_q    <= '0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            way_q       <= way_d;
            line_q      <= line_d;
            vtag_q      <= vtag_d;
            lo_q        <= lo_d;
            rhi_first_q <= rhi_first_d;
            rd_en_q     <= rd_en_d;
            rd_half_q   <= rd_half_d;
            wr_en_q     <= wr_en_d;
            wr_half_q   <= wr_half_d;
            wr_data_q   <= wr_data_d;
            wr_strb_q   <= wr_strb_d;
            wr_tag_en_q <= wr_tag_en_d;
            vc_en_q     <= vc_en_d;
            vc_way_q    <= vc_way_d;
            vc_data_q   <= vc_data_d;
            vc_tag_q    <= vc_tag_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

    assign req_ready_o      = ready_q;
    assign rd_l1d_en_o      = rd_en_q;
    assign rd_l1d_half_en_o = rd_half_q;
    assign rd_l1d_addr_o    = addr_q;
    assign wr_l1d_en_o      = wr_en_q;
    assign wr_l1d_half_en_o = wr_half_q;
    assign wr_l1d_addr_o    = addr_q;
    assign wr_l1d_data_o    = wr_data_q;
    assign wr_l1d_strb_o    = wr_strb_q;
    assign wr_l1d_tag_en_o  = wr_tag_en_q;
    assign wr_vc_en_o       = vc_en_q;
    assign wr_vc_line_en_o  = vc_en_q;
    assign wr_vc_way_o      = vc_way_q;
    assign wr_vc_data_o     = vc_data_q;
    assign wr_vc_tag_en_o   = vc_en_q;
    assign wr_vc_tag_o      = vc_tag_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;

endmodule

`default_nettype wire

// File: tb/tb_dcache_line_refill.sv
//------------------------------------------------------------------------------
// tb_dcache_line_refill
//   Randomized refill transactions against a transaction-level reference model.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dcache_line_refill;

    localparam int AWT = 32;
    localparam int TAG = 26;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [31:0]  req_addr_i;
    logic [1:0]   req_way_i;
    logic [511:0] req_data_i;
    logic         victim_valid_i;
    logic [25:0]  victim_tag_i;
    logic [3:0]   vc_valid_i;
    logic [1:0]   rd_l1d_en_o;
    logic [1:0]   rd_l1d_half_en_o;
    logic [31:0]  rd_l1d_addr_o;
    logic [511:0] rd_l1d_half_i;
    logic [1:0]   rw_conflict_i;
    logic [1:0]   wr_l1d_en_o;
    logic [1:0]   wr_l1d_half_en_o;
    logic [31:0]  wr_l1d_addr_o;
    logic [255:0] wr_l1d_data_o;
    logic [3:0]   wr_l1d_strb_o;
    logic [1:0]   wr_l1d_tag_en_o;
    logic         wr_vc_en_o;
    logic         wr_vc_line_en_o;
    logic [1:0]   wr_vc_way_o;
    logic [511:0] wr_vc_data_o;
    logic         wr_vc_tag_en_o;
    logic [25:0]  wr_vc_tag_o;
    logic         busy_o;
    logic         done_o;

    always #5 clk_i = ~clk_i;

    dcache_line_refill u_dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_addr_i       (req_addr_i),
        .req_way_i        (req_way_i),
        .req_data_i       (req_data_i),
        .victim_valid_i   (victim_valid_i),
        .victim_tag_i     (victim_tag_i),
        .vc_valid_i       (vc_valid_i),
        .rd_l1d_en_o      (rd_l1d_en_o),
        .rd_l1d_half_en_o (rd_l1d_half_en_o),
        .rd_l1d_addr_o    (rd_l1d_addr_o),
        .rd_l1d_half_i    (rd_l1d_half_i),
        .rw_conflict_i    (rw_conflict_i),
        .wr_l1d_en_o      (wr_l1d_en_o),
        .wr_l1d_half_en_o (wr_l1d_half_en_o),
        .wr_l1d_addr_o    (wr_l1d_addr_o),
        .wr_l1d_data_o    (wr_l1d_data_o),
        .wr_l1d_strb_o    (wr_l1d_strb_o),
        .wr_l1d_tag_en_o  (wr_l1d_tag_en_o),
        .wr_vc_en_o       (wr_vc_en_o),
        .wr_vc_line_en_o  (wr_vc_line_en_o),
        .wr_vc_way_o      (wr_vc_way_o),
        .wr_vc_data_o     (wr_vc_data_o),
        .wr_vc_tag_en_o   (wr_vc_tag_en_o),
        .wr_vc_tag_o      (wr_vc_tag_o),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    int n_cmp = 0;
    int n_err = 0;
    int rr_model = 0;

    task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One refill as seen from the pins. Cycle numbering counts the accept
    // cycle as cycle 1, so a clean fill reports done in cycle 4 (8 with eviction).
    task automatic run_txn(input logic [31:0] addr, input logic [1:0] way, input logic [511:0] line,
                           input logic vic, input logic [3:0] vcv, input int nlo, input int nhi,
                           input bit hold, input int rst_at);
        logic [25:0]  vtag;
        logic [255:0] vlo, vhi;
        logic [511:0] pend;
        logic [31:0]  aligned;
        logic [1:0]   exp_vc_way;
        logic [1:0]   wr_half_r [4];
        logic [255:0] wr_data_r [4];
        logic [1:0]   wr_tag_r  [4];
        logic [31:0]  wr_addr_r [4];
        logic [3:0]   wr_strb_r [4];
        logic [1:0]   vc_way_r;
        logic [511:0] vc_data_r;
        logic [25:0]  vc_tag_r;
        logic [1:0]   vc_aux_r;
        logic         cf;
        int widx, nrd, nwr, nvc, clo, chi, overlap, bad_rd, rdy_bad, done_cyc, accepted, exp_rd;
        bit found;

        vtag = 26'($urandom);
        vlo = rand512() >> 256;
        vhi = rand512() >> 256;
        aligned = addr & ~32'h3F;
        widx = way[1] ? 1 : 0;
        nrd = 0; nwr = 0; nvc = 0; clo = 0; chi = 0; overlap = 0; bad_rd = 0; rdy_bad = 0;
        done_cyc = 0; accepted = 0;
        vc_way_r = '0; vc_data_r = '0; vc_tag_r = '0; vc_aux_r = '0;
        for (int k = 0; k < 4; k++) begin
            wr_half_r[k] = '0; wr_data_r[k] = '0; wr_tag_r[k] = '0; wr_addr_r[k] = '0; wr_strb_r[k] = '0;
        end

        // Victim way: lowest free slot, otherwise the round-robin slot.
        found = 1'b0;
        exp_vc_way = 2'(rr_model);
        for (int i = 0; i < 4; i++) begin
            if (!found && !vcv[i]) begin
                exp_vc_way = 2'(i);
                found = 1'b1;
            end
        end

        req_valid_i    = 1'b1;
        req_addr_i     = addr;
        req_way_i      = way;
        req_data_i     = line;
        victim_valid_i = vic;
        victim_tag_i   = vtag;
        vc_valid_i     = vcv;
        for (int t = 0; t < 20 && accepted == 0; t++) begin
            if (req_ready_o) begin
                @(posedge clk_i);
                accepted = 1;
            end
            @(negedge clk_i);
        end
        check_eq("accept", 512'(accepted), 512'd1);
        if (!hold) req_valid_i = 1'b0;
        req_data_i     = rand512();
        victim_tag_i   = 26'($urandom);
        victim_valid_i = 1'($urandom);
        pend = rand512();

        for (int cyc = 1; cyc <= 60; cyc++) begin
            if ((|rd_l1d_en_o) && ((|wr_l1d_en_o) || wr_vc_en_o)) overlap++;
            if (|rd_l1d_en_o) begin
                nrd++;
                if (rd_l1d_en_o != way || rd_l1d_addr_o != aligned) bad_rd++;
            end
            if (|wr_l1d_en_o) begin
                if (nwr < 4) begin
                    wr_half_r[nwr] = wr_l1d_half_en_o;
                    wr_data_r[nwr] = wr_l1d_data_o;
                    wr_tag_r[nwr]  = wr_l1d_tag_en_o;
                    wr_addr_r[nwr] = wr_l1d_addr_o;
                    wr_strb_r[nwr] = wr_l1d_strb_o;
                end
                if (wr_l1d_en_o != way) bad_rd++;
                nwr++;
            end
            if (wr_vc_en_o) begin
                nvc++;
                vc_way_r  = wr_vc_way_o;
                vc_data_r = wr_vc_data_o;
                vc_tag_r  = wr_vc_tag_o;
                vc_aux_r  = {wr_vc_line_en_o, wr_vc_tag_en_o};
            end
            if (busy_o && req_ready_o) rdy_bad++;
            if (done_o && done_cyc == 0) done_cyc = cyc;

            // RAM side: data answers the previous cycle's read, conflicts are random.
            rd_l1d_half_i = pend;
            cf = 1'b0;
            if (|rd_l1d_en_o) begin
                if (rd_l1d_half_en_o == 2'b10 && clo < nlo) begin cf = 1'b1; clo++; end
                else if (rd_l1d_half_en_o == 2'b11 && chi < nhi) begin cf = 1'b1; chi++; end
            end
            rw_conflict_i = (cf ? way : 2'b00) | (~way & 2'($urandom));
            pend = rand512();
            if ((|rd_l1d_en_o) && !cf) pend[widx*256 +: 256] = (rd_l1d_half_en_o == 2'b11) ? vhi : vlo;

            if (rst_at != 0 && cyc == rst_at) rst_i = 1'b0;
            if (rst_at != 0 && cyc == rst_at + 1) begin
                check_eq("rst_quiet", {rd_l1d_en_o, wr_l1d_en_o, wr_l1d_tag_en_o, wr_vc_en_o, busy_o, done_o}, 512'd0);
                rst_i = 1'b1;
            end
            if (rst_at != 0 && cyc == rst_at + 2) check_eq("rst_ready", 512'(req_ready_o), 512'd1);
            if (rst_at == 0 && done_cyc != 0) break;
            if (rst_at != 0 && cyc == rst_at + 6) break;
            @(negedge clk_i);
        end
        rw_conflict_i = '0;

        if (rst_at == 0) begin
            exp_rd = vic ? 2 + nlo + nhi : 0;
            check_eq("done_cycle", 512'(done_cyc + 1), 512'(vic ? 8 + nlo + nhi : 4));
            check_eq("rd_count", 512'(nrd), 512'(exp_rd));
            check_eq("wr_count", 512'(nwr), 512'd2);
            check_eq("wr0_half", 512'(wr_half_r[0]), 512'(2'b10));
            check_eq("wr0_data", 512'(wr_data_r[0]), 512'(line[255:0]));
            check_eq("wr0_tag", 512'(wr_tag_r[0]), 512'd0);
            check_eq("wr1_half", 512'(wr_half_r[1]), 512'(2'b11));
            check_eq("wr1_data", 512'(wr_data_r[1]), 512'(line[511:256]));
            check_eq("wr1_tag", 512'(wr_tag_r[1]), 512'(way));
            check_eq("wr_addr", {wr_addr_r[0], wr_addr_r[1]}, {aligned, aligned});
            check_eq("wr_strb", 512'({wr_strb_r[0], wr_strb_r[1]}), 512'(8'hFF));
            check_eq("vc_count", 512'(nvc), 512'(vic));
            if (vic) begin
                check_eq("vc_way", 512'(vc_way_r), 512'(exp_vc_way));
                check_eq("vc_data", vc_data_r, {vhi, vlo});
                check_eq("vc_tag", 512'(vc_tag_r), 512'(vtag));
                check_eq("vc_line_tag_en", 512'(vc_aux_r), 512'(2'b11));
                if (!found) rr_model = (rr_model + 1) % 4;
            end
        end else begin
            check_eq("rst_no_wr", 512'(nwr + nvc), 512'd0);
            check_eq("rst_no_done", 512'(done_cyc), 512'd0);
            rr_model = 0;
        end
        check_eq("rd_wr_overlap", 512'(overlap), 512'd0);
        check_eq("rd_way_addr", 512'(bad_rd), 512'd0);
        check_eq("ready_busy", 512'(rdy_bad), 512'd0);
    endtask

    function automatic logic [1:0] rand_way();
        return ($urandom % 2 == 0) ? 2'b01 : 2'b10;
    endfunction

    initial begin
        rst_i          = 1'b0;
        req_valid_i    = 1'b0;
        req_addr_i     = '0;
        req_way_i      = '0;
        req_data_i     = '0;
        victim_valid_i = 1'b0;
        victim_tag_i   = '0;
        vc_valid_i     = '0;
        rd_l1d_half_i  = '0;
        rw_conflict_i  = '0;
        repeat (3) @(negedge clk_i);
        check_eq("reset_outs", {rd_l1d_en_o, wr_l1d_en_o, wr_l1d_tag_en_o, wr_vc_en_o, busy_o, done_o,
                                rd_l1d_addr_o, wr_l1d_data_o, wr_vc_data_o[255:0]}, 512'd0);
        check_eq("reset_ready", 512'(req_ready_o), 512'd1);
        rst_i = 1'b1;
        @(negedge clk_i);

        run_txn(32'h1000_0040, 2'b01, rand512(), 1'b0, 4'b0000, 0, 0, 1'b0, 0);
        run_txn($urandom, 2'b10, {{64{4'hA}}, {64{4'h5}}}, 1'b1, 4'b0101, 0, 0, 1'b0, 0);
        repeat (5) run_txn($urandom, rand_way(), rand512(), 1'b1, 4'b1111, 0, 0, 1'b0, 0);
        run_txn($urandom, rand_way(), rand512(), 1'b1, 4'($urandom), 2, 0, 1'b0, 0);
        run_txn($urandom, rand_way(), rand512(), 1'b1, 4'b1111, 0, 0, 1'b0, 3);
        run_txn($urandom, rand_way(), rand512(), 1'b1, 4'b1111, 0, 0, 1'b1, 0);
        run_txn($urandom, rand_way(), rand512(), 1'b0, 4'b1111, 0, 0, 1'b0, 0);
        repeat (16) begin
            run_txn($urandom, rand_way(), rand512(), 1'($urandom), 4'($urandom),
                    int'($urandom % 3), int'($urandom % 3), 1'b0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
